// File: rtl/mdu_pkg.sv
// Shared CPU definitions: ALU and MDU operation codes and the MDU sequencer states.
package mdu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring shift-subtract step per cycle on magnitudes, sign fixed at the end.
module mdu
  import mdu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N) + 1;

  mdu_state_e       state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [2*N-1:0]   acc_reg, acc_step;
  logic [N-1:0]     opb_reg, hi_reg, lo_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg, done_reg, dz_reg;

  logic             accept, is_mul, is_dv, signed_op, x_neg, y_neg, y_zero, run_go, last_step;
  logic [N-1:0]     xm, ym;
  logic [N:0]       add_a, add_b, sum;
  logic             sub, fits;
  logic [N-1:0]     rem_n;
  logic [2*N-1:0]   prod_fix;
  logic [N-1:0]     q_fix, r_fix;

  assign accept    = start && (state_reg == MDU_IDLE);
  assign is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_dv     = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign x_neg     = signed_op && x[N-1];
  assign y_neg     = signed_op && y[N-1];
  assign xm        = x_neg ? -x : x;
  assign ym        = y_neg ? -y : y;
  assign y_zero    = (y == '0);
  assign run_go    = accept && (is_mul || (is_dv && !y_zero));
  assign last_step = (state_reg == MDU_RUN) && (count_reg == CW'(1));

  // Shared N+1-bit adder: accumulate multiplicand, or trial-subtract divisor.
  always_comb begin
    sub   = is_div_reg;
    add_a = is_div_reg ? acc_reg[2*N-1:N-1] : {1'b0, acc_reg[2*N-1:N]};
    add_b = (is_div_reg || acc_reg[0]) ? {1'b0, opb_reg} : '0;
    sum   = add_a + (sub ? ~add_b : add_b) + (N+1)'(sub);
    fits  = !sum[N];
    rem_n = fits ? sum[N-1:0] : add_a[N-1:0];
    if (is_div_reg)
      acc_step = {rem_n, acc_reg[N-2:0], fits};
    else
      acc_step = {sum, acc_reg[N-1:1]};
    prod_fix = neg_q_reg ? -acc_step : acc_step;
    q_fix    = neg_q_reg ? -acc_step[N-1:0] : acc_step[N-1:0];
    r_fix    = neg_r_reg ? -acc_step[2*N-1:N] : acc_step[2*N-1:N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= MDU_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MDU_IDLE: if (run_go) state_next = MDU_RUN;
      MDU_RUN:  if (count_reg == CW'(1)) state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      if (run_go) begin
        count_reg  <= CW'(N);
        is_div_reg <= is_dv;
        neg_q_reg  <= x_neg ^ y_neg;
        neg_r_reg  <= x_neg;
        opb_reg    <= is_dv ? ym : xm;
        acc_reg    <= {{N{1'b0}}, (is_dv ? xm : ym)};
      end else if (accept) begin
        // Non-iterating requests finish in the cycle after accept.
        if (op == MDU_MTHI) begin
          hi_reg   <= x;
          done_reg <= 1'b1;
        end else if (op == MDU_MTLO) begin
          lo_reg   <= x;
          done_reg <= 1'b1;
        end else if (is_dv) begin
          done_reg <= 1'b1;
          dz_reg   <= 1'b1;
        end
      end else if (state_reg == MDU_RUN) begin
        acc_reg   <= acc_step;
        count_reg <= count_reg - CW'(1);
        if (last_step) begin
          done_reg <= 1'b1;
          if (is_div_reg) begin
            hi_reg <= r_fix;
            lo_reg <= q_fix;
          end else begin
            hi_reg <= prod_fix[2*N-1:N];
            lo_reg <= prod_fix[N-1:0];
          end
        end
      end
    end
  end

  assign busy        = (state_reg == MDU_RUN);
  assign done        = done_reg;
  assign div_by_zero = dz_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu (N=32): results, latency, busy span, flags, reset abort.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] x = '0, y = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  mdu #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to done; lat is the expected done cycle after accept.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input bit edz, input bit poke);
    int bc;
    int dk;
    bc = 0;
    dk = -1;
    @(negedge clk);
    op = o; x = a; y = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (lat > 1 && k == 5) begin
        check_val({name, "_hold_hi"}, {32'd0, hi}, {32'd0, cur_hi});
        check_val({name, "_hold_lo"}, {32'd0, lo}, {32'd0, cur_lo});
      end
      if (poke && k == 5) begin
        op = MDU_MULT; x = 32'd9; y = 32'd9; start = 1'b1;
      end
      if (poke && k == 6) start = 1'b0;
      if (done) begin
        dk = k;
        break;
      end
    end
    start = 1'b0;
    check_val({name, "_latency"}, 64'(dk), 64'(lat));
    check_val({name, "_busy_cycles"}, 64'(bc), 64'(lat - 1));
    check_val({name, "_hi"}, {32'd0, hi}, {32'd0, eh});
    check_val({name, "_lo"}, {32'd0, lo}, {32'd0, el});
    check_val({name, "_dz"}, {63'd0, div_by_zero}, {63'd0, edz});
    @(negedge clk);
    check_val({name, "_done_pulse"}, {63'd0, done}, 64'd0);
    cur_hi = eh;
    cur_lo = el;
    $display("txn %s op=%0d x=%h y=%h -> hi=%h lo=%h done_cycle=%0d busy=%0d dz=%0b",
             name, o, a, b, hi, lo, dk, bc, edz);
  endtask

  initial begin
    int seen;
    #2;
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_hi_lo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult_neg",   MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0, 1'b0);
    run_op("multu_max",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b0, 1'b0);
    run_op("mult_minsq", MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0, 1'b0);
    run_op("div_neg",    MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0, 1'b0);
    run_op("divu",       MDU_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        33, 1'b0, 1'b0);
    run_op("div_negy",   MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b0, 1'b0);
    run_op("div_ovf",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 1'b0, 1'b0);
    run_op("mthi",       MDU_MTHI,  32'd5,        32'd0,        32'd5,        cur_lo,       1,  1'b0, 1'b0);
    run_op("div_zero",   MDU_DIV,   32'd100,      32'd0,        32'd5,        cur_lo,       1,  1'b1, 1'b0);
    run_op("mtlo",       MDU_MTLO,  32'h1234,     32'd0,        cur_hi,       32'h1234,     1,  1'b0, 1'b0);
    run_op("multu_poke", MDU_MULTU, 32'd100,      32'd200,      32'd0,        32'd20000,    33, 1'b0, 1'b1);

    // Unused op code: accepted but silent.
    @(negedge clk);
    op = 3'd7; x = 32'hDEAD; y = 32'hBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check_val("unused_silent", 64'(seen), 64'd0);
    check_val("unused_hi_lo", {hi, lo}, {cur_hi, cur_lo});
    $display("txn unused op=7 -> hi=%h lo=%h activity=%0d", hi, lo, seen);

    // Reset at RUN step 10 aborts with no later done.
    @(negedge clk);
    op = MDU_MULT; x = 32'd3; y = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_busy", {63'd0, busy}, 64'd0);
    check_val("abort_done_dz", {62'd0, done, div_by_zero}, 64'd0);
    check_val("abort_hi_lo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check_val("abort_no_done", 64'(seen), 64'd0);
    $display("txn reset_abort -> busy=%0b hi=%h lo=%h late_activity=%0d", busy, hi, lo, seen);
    cur_hi = '0;
    cur_lo = '0;

    run_op("divu_after", MDU_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 33, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
